// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// instruction field positions and a saturating counter helper.
package pipeline_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } mc_state_e;

   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;

   localparam logic [4:0] REG_ZERO = 5'd0;

   function automatic logic [31:0] sat_inc32(input logic [31:0] value);
      sat_inc32 = (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/hazard_multicycle_timer.sv
// RUN/MC_WAIT sequencer that keeps a multi-cycle ALU op in EX for exactly
// MULT_LATENCY cycles; a flush or reset returns it to RUN with a cleared count.
module hazard_multicycle_timer
   import pipeline_pkg::*;
#(
   parameter int MULT_LATENCY = 4,
   parameter int CNT_W        = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic start_i,
   input  logic flush_i,
   output logic hold_o,
   output logic busy_o
);

   mc_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // State and down-counter registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= RUN;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and hold decode; entry cycle counts as the first EX cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_o  = 1'b0;
      case (state_q)
         RUN: begin
            if (start_i) begin
               hold_o  = 1'b1;
               state_d = MC_WAIT;
               cnt_d   = CNT_W'(MULT_LATENCY - 2);
            end else begin
               state_d = RUN;
            end
         end
         MC_WAIT: begin
            if (cnt_q != {CNT_W{1'b0}}) begin
               hold_o = 1'b1;
               cnt_d  = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
      if (flush_i) begin
         state_d = RUN;
         cnt_d   = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_d;
      end
   end

   assign busy_o = (state_q == MC_WAIT);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline register enable/bubble generation for load-use, branch flush and
// multi-cycle EX hold. Optional counters enabled with HAZARD_STATS_EN.
module pipeline_hazard_controller
   import pipeline_pkg::*;
#(
   parameter int MULT_LATENCY = 4,
   parameter int CNT_W        = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] ID_Instruction,
   input  logic        ID_UsesRt,
   input  logic        EX_MemRead,
   input  logic        EX_RegWrite,
   input  logic [4:0]  EX_WriteReg,
   input  logic        EX_MultiCycle,
   input  logic        MEM_BranchTaken,
   output logic        PCWrite,
   output logic        IF_ID_Write,
   output logic        IF_ID_Flush,
   output logic        ID_EX_Write,
   output logic        ID_EX_Bubble,
   output logic        EX_MEM_Bubble,
   output logic        Busy
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0] StallCycles,
   output logic [31:0] FlushCount
`endif
);

   logic [4:0] rs_s, rt_s;
   logic       load_use_s, mc_start_s, hold_s, busy_s;
   logic       unused_instr_s;

   assign rs_s           = ID_Instruction[RS_MSB:RS_LSB];
   assign rt_s           = ID_Instruction[RT_MSB:RT_LSB];
   assign unused_instr_s = ^{ID_Instruction[31:26], ID_Instruction[15:0]};

   assign load_use_s = EX_MemRead & EX_RegWrite & (EX_WriteReg != REG_ZERO) &
                       ((EX_WriteReg == rs_s) | (ID_UsesRt & (EX_WriteReg == rt_s)));

   // A single-cycle "multi-cycle" op needs no hold at all.
   assign mc_start_s = (MULT_LATENCY >= 2) ? EX_MultiCycle : 1'b0;

   hazard_multicycle_timer #(
      .MULT_LATENCY (MULT_LATENCY),
      .CNT_W        (CNT_W)
   ) u_timer (
      .clk_i   (Clk),
      .reset_i (Reset),
      .start_i (mc_start_s),
      .flush_i (MEM_BranchTaken),
      .hold_o  (hold_s),
      .busy_o  (busy_s)
   );

   // Priority mux: reset, branch flush, multi-cycle hold, load-use stall.
   always_comb begin
      PCWrite       = 1'b1;
      IF_ID_Write   = 1'b1;
      IF_ID_Flush   = 1'b0;
      ID_EX_Write   = 1'b1;
      ID_EX_Bubble  = 1'b0;
      EX_MEM_Bubble = 1'b0;
      Busy          = busy_s;
      if (Reset) begin
         PCWrite       = 1'b0;
         IF_ID_Write   = 1'b0;
         ID_EX_Write   = 1'b0;
         IF_ID_Flush   = 1'b1;
         ID_EX_Bubble  = 1'b1;
         EX_MEM_Bubble = 1'b1;
         Busy          = 1'b0;
      end else if (MEM_BranchTaken) begin
         IF_ID_Flush   = 1'b1;
         ID_EX_Bubble  = 1'b1;
         EX_MEM_Bubble = 1'b1;
      end else if (hold_s) begin
         PCWrite       = 1'b0;
         IF_ID_Write   = 1'b0;
         ID_EX_Write   = 1'b0;
         EX_MEM_Bubble = 1'b1;
      end else if (!busy_s && load_use_s) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Bubble = 1'b1;
      end else begin
         PCWrite = 1'b1;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_q, flush_q;

   // Saturating stall-cycle and branch-flush counters.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         stall_q <= 32'd0;
         flush_q <= 32'd0;
      end else begin
         if (!PCWrite) begin
            stall_q <= sat_inc32(stall_q);
         end
         if (MEM_BranchTaken) begin
            flush_q <= sat_inc32(flush_q);
         end
      end
   end

   assign StallCycles = stall_q;
   assign FlushCount  = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench for pipeline_hazard_controller (MULT_LATENCY=4).
module tb_pipeline_hazard_controller;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] ID_Instruction;
   logic        ID_UsesRt, EX_MemRead, EX_RegWrite, EX_MultiCycle, MEM_BranchTaken;
   logic [4:0]  EX_WriteReg;
   logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write;
   logic        ID_EX_Bubble, EX_MEM_Bubble, Busy;
`ifdef HAZARD_STATS_EN
   logic [31:0] StallCycles, FlushCount;
   int          exp_stall = 0;
   int          exp_flush = 0;
`endif

   int checks = 0;
   int errors = 0;

   // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble, Busy}
   localparam logic [6:0] DEF   = 7'b1101000;
   localparam logic [6:0] RST   = 7'b0010110;
   localparam logic [6:0] LU    = 7'b0001100;
   localparam logic [6:0] HOLD0 = 7'b0000010;
   localparam logic [6:0] HOLDB = 7'b0000011;
   localparam logic [6:0] REL   = 7'b1101001;
   localparam logic [6:0] FL    = 7'b1111110;
   localparam logic [6:0] FLB   = 7'b1111111;

   logic [6:0] obs_s;
   assign obs_s = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
                   ID_EX_Bubble, EX_MEM_Bubble, Busy};

   always #5 Clk = ~Clk;

   pipeline_hazard_controller #(.MULT_LATENCY(4), .CNT_W(4)) dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .ID_Instruction  (ID_Instruction),
      .ID_UsesRt       (ID_UsesRt),
      .EX_MemRead      (EX_MemRead),
      .EX_RegWrite     (EX_RegWrite),
      .EX_WriteReg     (EX_WriteReg),
      .EX_MultiCycle   (EX_MultiCycle),
      .MEM_BranchTaken (MEM_BranchTaken),
      .PCWrite         (PCWrite),
      .IF_ID_Write     (IF_ID_Write),
      .IF_ID_Flush     (IF_ID_Flush),
      .ID_EX_Write     (ID_EX_Write),
      .ID_EX_Bubble    (ID_EX_Bubble),
      .EX_MEM_Bubble   (EX_MEM_Bubble),
      .Busy            (Busy)
`ifdef HAZARD_STATS_EN
      ,
      .StallCycles     (StallCycles),
      .FlushCount      (FlushCount)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs mid-cycle, advance past the edge.
   task automatic cyc(input string tag, input logic rst, input logic br, input logic mc,
                      input logic lw, input logic [4:0] wr, input logic [4:0] rs,
                      input logic [4:0] rt, input logic uses, input logic [6:0] exp);
      Reset           = rst;
      MEM_BranchTaken = br;
      EX_MultiCycle   = mc;
      EX_MemRead      = lw;
      EX_RegWrite     = lw;
      EX_WriteReg     = wr;
      ID_Instruction  = {6'd0, rs, rt, 16'h4020};
      ID_UsesRt       = uses;
      #3;
      check(tag, {25'd0, obs_s}, {25'd0, exp});
`ifdef HAZARD_STATS_EN
      if (!rst && !exp[6]) exp_stall++;
      if (!rst && br) exp_flush++;
      if (rst) begin
         exp_stall = 0;
         exp_flush = 0;
      end
`endif
      @(posedge Clk);
      #1;
   endtask

   initial begin
      //   tag          rst  br   mc   lw   wr     rs     rt    uses  exp
      cyc("reset0",    1'b1,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0, RST);
      cyc("reset1",    1'b1,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0, RST);
`ifdef HAZARD_STATS_EN
      check("stall_zero", StallCycles, 32'd0);
      check("flush_zero", FlushCount, 32'd0);
`endif
      cyc("idle",      1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0, DEF);
      cyc("lu_rs",     1'b0,1'b0,1'b0,1'b1,5'd8, 5'd8, 5'd9, 1'b1, LU);
      cyc("lu_after",  1'b0,1'b0,1'b0,1'b0,5'd8, 5'd8, 5'd9, 1'b1, DEF);
      cyc("lu_r0",     1'b0,1'b0,1'b0,1'b1,5'd0, 5'd0, 5'd0, 1'b1, DEF);
      cyc("lu_rt",     1'b0,1'b0,1'b0,1'b1,5'd9, 5'd8, 5'd9, 1'b1, LU);
      cyc("lu_rt_nu",  1'b0,1'b0,1'b0,1'b1,5'd9, 5'd8, 5'd9, 1'b0, DEF);
      cyc("lu_nomatch",1'b0,1'b0,1'b0,1'b1,5'd7, 5'd8, 5'd9, 1'b1, DEF);
      // Multi-cycle op, EX_MultiCycle held high through the wait
      cyc("mc_c0",     1'b0,1'b0,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0, HOLD0);
      cyc("mc_c1",     1'b0,1'b0,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0, HOLDB);
      cyc("mc_c2",     1'b0,1'b0,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0, HOLDB);
      cyc("mc_c3_lu",  1'b0,1'b0,1'b1,1'b1,5'd8, 5'd8, 5'd9, 1'b1, REL);
      cyc("mc_c4",     1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0, DEF);
      cyc("br_vs_lu",  1'b0,1'b1,1'b0,1'b1,5'd8, 5'd8, 5'd9, 1'b1, FL);
      cyc("br_vs_mc",  1'b0,1'b1,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0, FL);
      cyc("br_mc_aft", 1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0, DEF);
      // Branch while waiting with count 1
      cyc("bw_c0",     1'b0,1'b0,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0, HOLD0);
      cyc("bw_c1",     1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0, HOLDB);
      cyc("bw_br",     1'b0,1'b1,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0, FLB);
      cyc("bw_after",  1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0, DEF);
      // Reset while waiting with count 2, then a full-length op proves count cleared
      cyc("rw_c0",     1'b0,1'b0,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0, HOLD0);
      cyc("rw_rst",    1'b1,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0, RST);
      cyc("rw_after",  1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0, DEF);
      cyc("rw_m0",     1'b0,1'b0,1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b0, HOLD0);
      cyc("rw_m1",     1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0, HOLDB);
      cyc("rw_m2",     1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0, HOLDB);
      cyc("rw_m3",     1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0, REL);
      cyc("rw_m4",     1'b0,1'b0,1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0, DEF);
`ifdef HAZARD_STATS_EN
      check("stall_cnt", StallCycles, exp_stall);
      check("flush_cnt", FlushCount, exp_flush);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
